disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit, common-anode seven-segment display. It owns the `disp_an_o` and `disp_seg_o` pins and is driven by the processor or debug logic. It holds a 32-bit hex value plus decimal points in a shadow/active register pair, and rotates one digit at a time at a programmable rate. New values are applied only at frame boundaries, which prevents tearing, and each application is acknowledged.

---
 rtl/disp_scan_ctrl_if.sv | 26 ++
 rtl/disp_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/disp_scan_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_scan_ctrl_if : host-side and pin-side signals of the display scanner
// Rev 1.0
// ---------------------------------------------------------------------------
interface disp_scan_ctrl_if;
  logic [31:0] value_i;
  logic [7:0]  dp_i;
  logic [7:0]  digit_en_i;
  logic        load_i;
  logic        load_ack_o;
  logic        frame_o;
  logic [7:0]  disp_an_o;
  logic [7:0]  disp_seg_o;

  modport master (
    output value_i, dp_i, digit_en_i, load_i,
    input  load_ack_o, frame_o, disp_an_o, disp_seg_o
  );

  modport slave (
    input  value_i, dp_i, digit_en_i, load_i,
    output load_ack_o, frame_o, disp_an_o, disp_seg_o
  );
endinterface
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_scan_ctrl : 8-digit common-anode 7-seg scanner, tear-free frame loads
// Optional macro SCAN_BLANK_EN inserts an all-off BLANK slot after each digit.
// Rev 1.0
// ---------------------------------------------------------------------------
module disp_scan_ctrl #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input logic             clk_i,
  input logic             rst_i,
  disp_scan_ctrl_if.slave bus
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  typedef enum logic [0:0] {S_DRIVE = 1'b0, S_BLANK = 1'b1} state_t;
`else
  typedef enum logic [0:0] {S_DRIVE = 1'b0} state_t;
`endif

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shadow_val_q, shadow_val_d;
  logic [7:0]       shadow_dp_q, shadow_dp_d;
  logic [31:0]      active_val_q, active_val_d;
  logic [7:0]       active_dp_q, active_dp_d;
  logic             pending_q, pending_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             ack_q, ack_d;
  logic             frame_q, frame_d;
  logic             boundary;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan sequencing; pin values are registered, so they trail the state by one cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    an_d     = 8'hFF;
    seg_d    = 8'hFF;
    case (state_q)
      S_DRIVE: begin
        an_d[idx_q] = ~bus.digit_en_i[idx_q];
        seg_d       = {~active_dp_q[idx_q], hex7(active_val_q[{idx_q, 2'b00} +: 4])};
        if (cnt_q == DIGIT_LAST) begin
          cnt_d = '0;
`ifdef SCAN_BLANK_EN
          state_d = S_BLANK;
`else
          idx_d    = idx_q + 3'd1;
          boundary = (idx_q == 3'd7);
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d    = '0;
          state_d  = S_DRIVE;
          idx_d    = idx_q + 3'd1;
          boundary = (idx_q == 3'd7);
        end
      end
`endif
      default: begin
        state_d = S_DRIVE;
      end
    endcase
  end

  // A load landing on the boundary goes straight to active and supersedes the shadow.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    ack_d        = 1'b0;
    frame_d      = boundary;
    if (boundary) begin
      if (bus.load_i) begin
        active_val_d = bus.value_i;
        active_dp_d  = bus.dp_i;
        pending_d    = 1'b0;
        ack_d        = 1'b1;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
        ack_d        = 1'b1;
      end
    end else if (bus.load_i) begin
      shadow_val_d = bus.value_i;
      shadow_dp_d  = bus.dp_i;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_DRIVE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
      ack_q        <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      ack_q        <= ack_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.disp_an_o  = an_q;
  assign bus.disp_seg_o = seg_q;
  assign bus.load_ack_o = ack_q;
  assign bus.frame_o    = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_disp_scan_ctrl : randomized bench for disp_scan_ctrl against a frame-position model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_disp_scan_ctrl;

  localparam int DIGIT = 4;
  localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
  localparam int GAP = BLANK;
`else
  localparam int GAP = 0;
`endif
  localparam int SLOT  = DIGIT + GAP;
  localparam int FRAME = 8 * SLOT;

  logic clk;
  logic rst;
  disp_scan_ctrl_if bus();

  disp_scan_ctrl #(.DIGIT_TICKS(DIGIT), .BLANK_TICKS(BLANK)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int vec_cnt = 0;
  int err_cnt = 0;
  int n       = 0;

  logic [31:0] m_act_v, m_sh_v;
  logic [7:0]  m_act_dp, m_sh_dp;
  logic        m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act_v = '0; m_act_dp = '0; m_sh_v = '0; m_sh_dp = '0; m_pend = 1'b0; n = 0;
  endtask

  // One clock: drive inputs, predict pins from the position within the frame, compare.
  task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] d,
                      input logic [7:0] en);
    int p, slot, w;
    logic [7:0] exp_an, exp_seg;
    logic [3:0] nib;
    logic       exp_frame, exp_ack;
    @(negedge clk);
    bus.load_i = ld; bus.value_i = v; bus.dp_i = d; bus.digit_en_i = en;
    @(posedge clk);
    p = n % FRAME; slot = p / SLOT; w = p % SLOT;
    exp_an = 8'hFF; exp_seg = 8'hFF;
    if (w < DIGIT) begin
      nib     = 4'((m_act_v >> (4 * slot)) & 32'hF);
      exp_seg = {~m_act_dp[slot], seg_tbl[nib]};
      if (en[slot]) exp_an[slot] = 1'b0;
    end
    exp_frame = (p == FRAME - 1);
    exp_ack   = 1'b0;
    if (exp_frame) begin
      if (ld) begin
        m_act_v = v; m_act_dp = d; m_pend = 1'b0; exp_ack = 1'b1;
      end else if (m_pend) begin
        m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_pend = 1'b0; exp_ack = 1'b1;
      end
    end else if (ld) begin
      m_sh_v = v; m_sh_dp = d; m_pend = 1'b1;
    end
    #1;
    check("an",    {24'd0, bus.disp_an_o},  {24'd0, exp_an});
    check("seg",   {24'd0, bus.disp_seg_o}, {24'd0, exp_seg});
    check("ack",   {31'd0, bus.load_ack_o}, {31'd0, exp_ack});
    check("frame", {31'd0, bus.frame_o},    {31'd0, exp_frame});
    n++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_an"},  {24'd0, bus.disp_an_o},  32'hFF);
    check({tag, "_seg"}, {24'd0, bus.disp_seg_o}, 32'hFF);
    check({tag, "_ack"}, {31'd0, bus.load_ack_o}, 32'h0);
    check({tag, "_frm"}, {31'd0, bus.frame_o},    32'h0);
  endtask

  initial begin
    bus.load_i = 1'b0; bus.value_i = '0; bus.dp_i = '0; bus.digit_en_i = 8'hFF;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_idle("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("rst_hold");
    end
    #1 rst = 1'b0;
    model_reset();

    // Directed load at cycle 10; ack lands with the frame pulse
    for (int i = 0; i < FRAME; i++) step(i == 10, 32'h89ABCDE7, 8'h01, 8'hFF);
    for (int i = 0; i < FRAME; i++) step(1'b0, $urandom, 8'($urandom), 8'hFF);
    for (int i = 0; i < FRAME; i++) step(1'b0, $urandom, 8'($urandom), 8'hF0);
    // Two loads in one frame: last wins, single ack
    for (int i = 0; i < FRAME; i++)
      step(i == 5 || i == 20, (i == 5) ? 32'h11111111 : 32'h22222222, 8'h00, 8'hFF);
    // Load exactly on the boundary bypasses the shadow
    for (int i = 0; i < FRAME; i++) step(i == FRAME - 1, 32'h00000005, 8'h00, 8'hFF);
    for (int i = 0; i < FRAME; i++) step(1'b0, $urandom, 8'($urandom), 8'hFF);

    for (int i = 0; i < 8 * FRAME; i++) begin
      logic ld;
      logic [7:0] en;
      ld = ($urandom_range(0, 9) == 0) || ((i % FRAME == FRAME - 1) && ($urandom_range(0, 1) == 1));
      en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      step(ld, $urandom, 8'($urandom), en);
    end

    // Asynchronous reset while digit 3 is driven
    for (int i = 0; i < 3 * SLOT + 2; i++) step(i == 4, 32'hDEADBEEF, 8'hA5, 8'hFF);
    #2 rst = 1'b1;
    #1 check_idle("rst_mid");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_idle("rst_mid_hold");
    end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++)
      step($urandom_range(0, 15) == 0, $urandom, 8'($urandom), 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
